// File: rtl/csr_timer_unit.sv
// Machine-mode CSR file with 64-bit mtime/mtimecmp timer, CSR RMW, MRET and timer trap entry.
// Optional mcycle/minstret counters are enabled by defining CSR_CYCLE_COUNTERS_EN.
`ifndef InstTypeBus
`define InstTypeBus 3:0
`endif

module csr_timer_unit #(
    parameter logic [31:0] MTVEC_RST    = 32'h0000_0000,
    parameter logic [63:0] MTIMECMP_RST = 64'hFFFF_FFFF_FFFF_FFFF
) (
    input  logic                clk_in,
    input  logic                rst_in,
    input  logic                rdy_in,
    input  logic [5:0]          stall,
    input  logic [`InstTypeBus] inst_type_in,
    input  logic [31:0]         rs1_val_in,
    input  logic [31:0]         imm_in,
    input  logic [11:0]         csr_addr_in,
    input  logic [31:0]         pc_in,
    output logic [31:0]         csr_rdata_out,
    output logic                timer_interrupt,
    output logic                redirect_out,
    output logic [31:0]         redirect_pc_out
);

    localparam logic [3:0] InstNop    = 4'd0;
    localparam logic [3:0] InstCsrrw  = 4'd1;
    localparam logic [3:0] InstCsrrs  = 4'd2;
    localparam logic [3:0] InstCsrrc  = 4'd3;
    localparam logic [3:0] InstCsrrwi = 4'd4;
    localparam logic [3:0] InstCsrrsi = 4'd5;
    localparam logic [3:0] InstCsrrci = 4'd6;
    localparam logic [3:0] InstMret   = 4'd7;

    localparam logic       NotStop = 1'b0;
    localparam logic [0:0] StRun   = 1'b0;
    localparam logic [0:0] StTrap  = 1'b1;

    logic [0:0]  state_q, state_d;
    logic        mie_q, mie_d, mpie_q, mpie_d, mtie_q, mtie_d;
    logic [31:2] mtvec_q, mtvec_d, mepc_q, mepc_d;
    logic [31:0] mcause_q, mcause_d;
    logic [63:0] mtime_q, mtime_d, mtimecmp_q, mtimecmp_d;
`ifdef CSR_CYCLE_COUNTERS_EN
    logic [63:0] mcycle_q, mcycle_d, minstret_q, minstret_d;
`endif

    logic        advance, mtip, is_csr, is_imm, is_w, take, mret_go, csr_we;
    logic [31:0] src, csr_wdata;
    logic [3:0]  itype;

    assign itype   = inst_type_in;
    assign advance = rdy_in & (stall[3] == NotStop);
    assign mtip    = (mtime_q >= mtimecmp_q);
    assign is_csr  = (itype >= InstCsrrw) && (itype <= InstCsrrci);
    assign is_imm  = (itype >= InstCsrrwi) && (itype <= InstCsrrci);
    assign is_w    = (itype == InstCsrrw) || (itype == InstCsrrwi);
    assign src     = is_imm ? imm_in : rs1_val_in;

    // Trap decision uses only pre-write state, so a same-cycle MIE clear cannot block it.
    assign take    = (state_q == StRun) & mie_q & mtie_q & mtip & advance &
                     (itype != InstNop) & (itype != InstMret);
    assign mret_go = (state_q == StRun) & advance & (itype == InstMret) & ~take;
    assign csr_we  = (state_q == StRun) & advance & is_csr & ~take & (is_w | (src != 32'd0));

    logic unused_ok;
    assign unused_ok = ^{stall[5:4], stall[2:0], pc_in[1:0]};

    always_comb begin
        csr_rdata_out = 32'd0;
        case (csr_addr_in)
            12'h300: csr_rdata_out = {24'd0, mpie_q, 3'd0, mie_q, 3'd0};
            12'h304: csr_rdata_out = {24'd0, mtie_q, 7'd0};
            12'h344: csr_rdata_out = {24'd0, mtip, 7'd0};
            12'h305: csr_rdata_out = {mtvec_q, 2'b00};
            12'h341: csr_rdata_out = {mepc_q, 2'b00};
            12'h342: csr_rdata_out = mcause_q;
            12'h7C0: csr_rdata_out = mtimecmp_q[31:0];
            12'h7C1: csr_rdata_out = mtimecmp_q[63:32];
            12'h7C2: csr_rdata_out = mtime_q[31:0];
            12'h7C3: csr_rdata_out = mtime_q[63:32];
`ifdef CSR_CYCLE_COUNTERS_EN
            12'hB00: csr_rdata_out = mcycle_q[31:0];
            12'hB80: csr_rdata_out = mcycle_q[63:32];
            12'hB02: csr_rdata_out = minstret_q[31:0];
            12'hB82: csr_rdata_out = minstret_q[63:32];
`endif
            default: csr_rdata_out = 32'd0;
        endcase
    end

    always_comb begin
        csr_wdata = src;
        case (itype)
            InstCsrrs, InstCsrrsi: csr_wdata = csr_rdata_out | src;
            InstCsrrc, InstCsrrci: csr_wdata = csr_rdata_out & ~src;
            default:               csr_wdata = src;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        mie_d      = mie_q;
        mpie_d     = mpie_q;
        mtie_d     = mtie_q;
        mtvec_d    = mtvec_q;
        mepc_d     = mepc_q;
        mcause_d   = mcause_q;
        mtimecmp_d = mtimecmp_q;
        mtime_d    = rdy_in ? mtime_q + 64'd1 : mtime_q;
`ifdef CSR_CYCLE_COUNTERS_EN
        mcycle_d   = rdy_in ? mcycle_q + 64'd1 : mcycle_q;
        minstret_d = (advance & (state_q == StRun) & ~take & (itype != InstNop)) ?
                     minstret_q + 64'd1 : minstret_q;
`endif
        if (csr_we) begin
            case (csr_addr_in)
                12'h300: begin
                    mie_d  = csr_wdata[3];
                    mpie_d = csr_wdata[7];
                end
                12'h304: mtie_d = csr_wdata[7];
                12'h305: mtvec_d = csr_wdata[31:2];
                12'h341: mepc_d = csr_wdata[31:2];
                12'h342: mcause_d = csr_wdata;
                12'h7C0: mtimecmp_d[31:0] = csr_wdata;
                12'h7C1: mtimecmp_d[63:32] = csr_wdata;
`ifdef CSR_CYCLE_COUNTERS_EN
                12'hB00: mcycle_d[31:0] = csr_wdata;
                12'hB80: mcycle_d[63:32] = csr_wdata;
                12'hB02: minstret_d[31:0] = csr_wdata;
                12'hB82: minstret_d[63:32] = csr_wdata;
`endif
                default: ;
            endcase
        end
        if (take) begin
            mepc_d   = pc_in[31:2];
            mcause_d = 32'h8000_0007;
            mpie_d   = mie_q;
            mie_d    = 1'b0;
            state_d  = StTrap;
        end else if (mret_go) begin
            mie_d  = mpie_q;
            mpie_d = 1'b1;
        end
        if ((state_q == StTrap) && rdy_in) begin
            state_d = StRun;
        end
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state_q    <= StRun;
            mie_q      <= 1'b0;
            mpie_q     <= 1'b0;
            mtie_q     <= 1'b0;
            mtvec_q    <= MTVEC_RST[31:2];
            mepc_q     <= 30'd0;
            mcause_q   <= 32'd0;
            mtime_q    <= 64'd0;
            mtimecmp_q <= MTIMECMP_RST;
`ifdef CSR_CYCLE_COUNTERS_EN
            mcycle_q   <= 64'd0;
            minstret_q <= 64'd0;
`endif
        end else begin
            state_q    <= state_d;
            mie_q      <= mie_d;
            mpie_q     <= mpie_d;
            mtie_q     <= mtie_d;
            mtvec_q    <= mtvec_d;
            mepc_q     <= mepc_d;
            mcause_q   <= mcause_d;
            mtime_q    <= mtime_d;
            mtimecmp_q <= mtimecmp_d;
`ifdef CSR_CYCLE_COUNTERS_EN
            mcycle_q   <= mcycle_d;
            minstret_q <= minstret_d;
`endif
        end
    end

    assign timer_interrupt = take;
    assign redirect_out    = take | mret_go;
    assign redirect_pc_out = take    ? {mtvec_q, 2'b00} :
                             mret_go ? {mepc_q, 2'b00}  : 32'd0;

endmodule

// File: tb/tb_csr_timer_unit.sv
// Directed self-checking bench for csr_timer_unit: CSR RMW, timer trap, MRET, stall/rdy gating, reset.
module tb_csr_timer_unit;

    localparam logic [3:0] Nop    = 4'd0;
    localparam logic [3:0] Csrrw  = 4'd1;
    localparam logic [3:0] Csrrs  = 4'd2;
    localparam logic [3:0] Csrrc  = 4'd3;
    localparam logic [3:0] Csrrci = 4'd6;
    localparam logic [3:0] Mret   = 4'd7;
    localparam logic [3:0] Alu    = 4'd8;

    logic        clk_in = 1'b0;
    logic        rst_in = 1'b1;
    logic        rdy_in = 1'b1;
    logic [5:0]  stall = 6'd0;
    logic [3:0]  inst_type = Nop;
    logic [31:0] rs1_val = 32'd0, imm = 32'd0, pc = 32'd0;
    logic [11:0] csr_addr = 12'd0;
    logic [31:0] csr_rdata, redirect_pc;
    logic        timer_interrupt, redirect;

    int checks = 0;
    int failures = 0;

    csr_timer_unit dut (
        .clk_in          (clk_in),
        .rst_in          (rst_in),
        .rdy_in          (rdy_in),
        .stall           (stall),
        .inst_type_in    (inst_type),
        .rs1_val_in      (rs1_val),
        .imm_in          (imm),
        .csr_addr_in     (csr_addr),
        .pc_in           (pc),
        .csr_rdata_out   (csr_rdata),
        .timer_interrupt (timer_interrupt),
        .redirect_out    (redirect),
        .redirect_pc_out (redirect_pc)
    );

    always #5 clk_in = ~clk_in;

    task automatic tick;
        @(posedge clk_in);
        #1;
    endtask

    task automatic drive(input logic [3:0] t, input logic [11:0] a, input logic [31:0] r,
                         input logic [31:0] i, input logic [31:0] p);
        inst_type = t;
        csr_addr  = a;
        rs1_val   = r;
        imm       = i;
        pc        = p;
        #1;
    endtask

    task automatic test_reset;
        rst_in = 1'b1;
        drive(Nop, 12'h305, 0, 0, 0);
        repeat (2) @(posedge clk_in);
        #1;
        checks++;
        if (timer_interrupt !== 1'b0 || redirect !== 1'b0 || redirect_pc !== 32'd0) begin
            failures++;
            $display("FAIL reset_outputs: ti=%b redir=%b pc=%h required 0/0/0",
                     timer_interrupt, redirect, redirect_pc);
        end
        checks++;
        if (csr_rdata !== 32'd0) begin
            failures++;
            $display("FAIL reset_mtvec: got %h required 0", csr_rdata);
        end
        drive(Nop, 12'h7C0, 0, 0, 0);
        checks++;
        if (csr_rdata !== 32'hFFFF_FFFF) begin
            failures++;
            $display("FAIL reset_mtimecmp: got %h required ffffffff", csr_rdata);
        end
        rst_in = 1'b0;
        drive(Nop, 12'h7C2, 0, 0, 0);
        checks++;
        if (csr_rdata !== 32'd0) begin
            failures++;
            $display("FAIL reset_mtime0: got %h required 0", csr_rdata);
        end
        tick();
        checks++;
        if (csr_rdata !== 32'd1) begin
            failures++;
            $display("FAIL mtime_inc: got %h required 1", csr_rdata);
        end
    endtask

    task automatic test_csrrw;
        drive(Csrrw, 12'h305, 32'h8000_0103, 0, 32'h100);
        checks++;
        if (csr_rdata !== 32'd0) begin
            failures++;
            $display("FAIL csrrw_old: got %h required 0", csr_rdata);
        end
        tick();
        drive(Nop, 12'h305, 0, 0, 0);
        checks++;
        if (csr_rdata !== 32'h8000_0100) begin
            failures++;
            $display("FAIL csrrw_mtvec: got %h required 80000100", csr_rdata);
        end
        tick();
    endtask

    task automatic test_timer_trap;
        bit seen = 0;
        drive(Csrrs, 12'h300, 32'h8, 0, 32'h104);   tick();
        drive(Csrrs, 12'h304, 32'h80, 0, 32'h108);  tick();
        drive(Csrrw, 12'h7C0, 32'd20, 0, 32'h10C);  tick();
        drive(Csrrw, 12'h7C1, 32'd0, 0, 32'h110);   tick();
        for (int k = 0; k < 100; k++) begin
            drive(Nop, 12'h344, 0, 0, 0);
            if (csr_rdata === 32'h80) begin
                seen = 1;
                break;
            end
            tick();
        end
        checks++;
        if (!seen) begin
            failures++;
            $display("FAIL mtip_wait: MTIP never set within 100 cycles");
        end
        drive(Alu, 12'h000, 0, 0, 32'h1000);
        checks++;
        if (timer_interrupt !== 1'b1 || redirect !== 1'b1 || redirect_pc !== 32'h8000_0100) begin
            failures++;
            $display("FAIL trap_take: ti=%b redir=%b pc=%h required 1/1/80000100",
                     timer_interrupt, redirect, redirect_pc);
        end
        tick();
        drive(Csrrw, 12'h341, 32'hDEAD_0000, 0, 32'h1004);
        checks++;
        if (timer_interrupt !== 1'b0 || redirect !== 1'b0) begin
            failures++;
            $display("FAIL trap_lockout: ti=%b redir=%b required 0/0", timer_interrupt, redirect);
        end
        tick();
        drive(Nop, 12'h341, 0, 0, 0);
        checks++;
        if (csr_rdata !== 32'h1000) begin
            failures++;
            $display("FAIL trap_mepc: got %h required 00001000", csr_rdata);
        end
        drive(Nop, 12'h342, 0, 0, 0);
        checks++;
        if (csr_rdata !== 32'h8000_0007) begin
            failures++;
            $display("FAIL trap_mcause: got %h required 80000007", csr_rdata);
        end
        drive(Nop, 12'h300, 0, 0, 0);
        checks++;
        if (csr_rdata !== 32'h80) begin
            failures++;
            $display("FAIL trap_mstatus: got %h required 00000080", csr_rdata);
        end
    endtask

    task automatic test_mret;
        drive(Mret, 12'h000, 0, 0, 32'h1010);
        checks++;
        if (redirect !== 1'b1 || redirect_pc !== 32'h1000 || timer_interrupt !== 1'b0) begin
            failures++;
            $display("FAIL mret_redirect: redir=%b pc=%h ti=%b required 1/00001000/0",
                     redirect, redirect_pc, timer_interrupt);
        end
        tick();
        drive(Nop, 12'h300, 0, 0, 0);
        checks++;
        if (csr_rdata !== 32'h88) begin
            failures++;
            $display("FAIL mret_mstatus: got %h required 00000088", csr_rdata);
        end
    endtask

    task automatic test_stall;
        stall = 6'b001000;
        drive(Alu, 12'h000, 0, 0, 32'h1100);
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (timer_interrupt !== 1'b0 || redirect !== 1'b0) begin
                failures++;
                $display("FAIL stall_no_pulse[%0d]: ti=%b redir=%b required 0/0",
                         k, timer_interrupt, redirect);
            end
            tick();
        end
        stall = 6'd0;
        #1;
        checks++;
        if (timer_interrupt !== 1'b1) begin
            failures++;
            $display("FAIL stall_release_pulse: ti=%b required 1", timer_interrupt);
        end
        tick();
        drive(Nop, 12'h341, 0, 0, 0);
        checks++;
        if (csr_rdata !== 32'h1100) begin
            failures++;
            $display("FAIL stall_mepc: got %h required 00001100", csr_rdata);
        end
        tick();
    endtask

    task automatic test_rdy;
        logic [31:0] t0;
        drive(Csrrs, 12'h300, 32'h8, 0, 32'h1200);
        tick();
        rdy_in = 1'b0;
        drive(Nop, 12'h7C2, 0, 0, 0);
        t0 = csr_rdata;
        drive(Alu, 12'h7C2, 0, 0, 32'h1204);
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (timer_interrupt !== 1'b0 || redirect !== 1'b0 || csr_rdata !== t0) begin
                failures++;
                $display("FAIL rdy_hold[%0d]: ti=%b redir=%b mtime=%h required 0/0/%h",
                         k, timer_interrupt, redirect, csr_rdata, t0);
            end
            tick();
        end
        rdy_in = 1'b1;
        #1;
        checks++;
        if (timer_interrupt !== 1'b1 || csr_rdata !== t0) begin
            failures++;
            $display("FAIL rdy_release: ti=%b mtime=%h required 1/%h",
                     timer_interrupt, csr_rdata, t0);
        end
        tick();
        drive(Nop, 12'h7C2, 0, 0, 0);
        checks++;
        if (csr_rdata !== t0 + 32'd1) begin
            failures++;
            $display("FAIL rdy_resume: mtime=%h required %h", csr_rdata, t0 + 32'd1);
        end
        tick();
    endtask

    task automatic test_csrrc_zero;
        drive(Csrrw, 12'h7C1, 32'hFFFF_FFFF, 0, 32'h1300); tick();
        drive(Mret, 12'h000, 0, 0, 32'h1304);              tick();
        drive(Csrrc, 12'h300, 32'd0, 0, 32'h1308);
        checks++;
        if (csr_rdata !== 32'h88) begin
            failures++;
            $display("FAIL csrrc0_old: got %h required 00000088", csr_rdata);
        end
        tick();
        drive(Csrrci, 12'h300, 32'hFFFF_FFFF, 32'd0, 32'h130C);
        tick();
        drive(Nop, 12'h300, 0, 0, 0);
        checks++;
        if (csr_rdata !== 32'h88) begin
            failures++;
            $display("FAIL csrrc0_nowrite: got %h required 00000088", csr_rdata);
        end
        drive(Csrrw, 12'hFFF, 32'h1234, 0, 32'h1310);
        checks++;
        if (csr_rdata !== 32'd0) begin
            failures++;
            $display("FAIL unimpl_old: got %h required 0", csr_rdata);
        end
        tick();
        drive(Nop, 12'hFFF, 0, 0, 0);
        checks++;
        if (csr_rdata !== 32'd0) begin
            failures++;
            $display("FAIL unimpl_read: got %h required 0", csr_rdata);
        end
        drive(Csrrc, 12'h300, 32'h80, 0, 32'h1314);
        tick();
        drive(Nop, 12'h300, 0, 0, 0);
        checks++;
        if (csr_rdata !== 32'h08) begin
            failures++;
            $display("FAIL csrrc_mpie: got %h required 00000008", csr_rdata);
        end
    endtask

    task automatic test_squash_and_reset;
        drive(Csrrw, 12'h7C1, 32'd0, 0, 32'h1400);
        tick();
        drive(Csrrw, 12'h341, 32'h5550, 0, 32'h2000);
        checks++;
        if (timer_interrupt !== 1'b1 || redirect_pc !== 32'h8000_0100) begin
            failures++;
            $display("FAIL squash_take: ti=%b pc=%h required 1/80000100",
                     timer_interrupt, redirect_pc);
        end
        tick();
        drive(Nop, 12'h341, 0, 0, 0);
        checks++;
        if (csr_rdata !== 32'h2000) begin
            failures++;
            $display("FAIL squash_mepc: got %h required 00002000", csr_rdata);
        end
        rst_in = 1'b1;
        drive(Nop, 12'h305, 0, 0, 0);
        checks++;
        if (timer_interrupt !== 1'b0 || redirect !== 1'b0 || csr_rdata !== 32'd0) begin
            failures++;
            $display("FAIL midtrap_reset: ti=%b redir=%b mtvec=%h required 0/0/0",
                     timer_interrupt, redirect, csr_rdata);
        end
        tick();
        tick();
        rst_in = 1'b0;
        drive(Nop, 12'h7C2, 0, 0, 0);
        checks++;
        if (csr_rdata !== 32'd0) begin
            failures++;
            $display("FAIL reset_mtime_restart: got %h required 0", csr_rdata);
        end
        tick();
        checks++;
        if (csr_rdata !== 32'd1) begin
            failures++;
            $display("FAIL reset_mtime_count: got %h required 1", csr_rdata);
        end
        drive(Nop, 12'h300, 0, 0, 0);
        checks++;
        if (csr_rdata !== 32'd0) begin
            failures++;
            $display("FAIL reset_mstatus: got %h required 0", csr_rdata);
        end
        drive(Nop, 12'hB00, 0, 0, 0);
        checks++;
`ifdef CSR_CYCLE_COUNTERS_EN
        if (csr_rdata !== 32'd1) begin
            failures++;
            $display("FAIL mcycle_read: got %h required 1", csr_rdata);
        end
`else
        if (csr_rdata !== 32'd0) begin
            failures++;
            $display("FAIL mcycle_absent: got %h required 0", csr_rdata);
        end
`endif
    endtask

    initial begin
        test_reset();
        test_csrrw();
        test_timer_trap();
        test_mret();
        test_stall();
        test_rdy();
        test_csrrc_zero();
        test_squash_and_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
